shift_register_multitap: RTL and testbench
==========================================

SHIFT_REGISTER_MULTITAP -- requirements
Module: shift_register_multitap

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 16, number of stored words; legal range 2..1024.
REQ-003 SHALL have parameter NUM_TAPS, default 2, number of independent dynamic read ports; legal range 1..8.
REQ-004 SHALL have parameter NUM_REGISTER_OUTPUT, default 0, read latency; legal values 0 or 1.
REQ-005 SHALL define localparam AW = $clog2(DEPTH) and CW = $clog2(DEPTH+1).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 wea  input  1  push dia onto the front (position 0).
REQ-009 dia  input  DATA_WIDTH  push data.
REQ-010 flush  input  1  synchronous clear of fill tracking.
REQ-011 reb  input  NUM_TAPS  per-tap read enable; used only when NUM_REGISTER_OUTPUT=1.
REQ-012 addrb  input  NUM_TAPS*AW  per-tap read position; tap t occupies bits [t*AW +: AW].
REQ-013 dob  output  NUM_TAPS*DATA_WIDTH  per-tap read data; tap t occupies bits [t*DATA_WIDTH +: DATA_WIDTH].
REQ-014 dob_valid  output  NUM_TAPS  per-tap flag: the addressed position holds a word pushed since reset/flush.
REQ-015 addr_err  output  NUM_TAPS  per-tap flag: addrb >= DEPTH.
REQ-016 fill_count  output  CW  number of valid words, saturating at DEPTH.
REQ-017 full  output  1  fill_count == DEPTH.

Function
REQ-018 On clk edge with wea=1: sr[0] <= dia, sr[i] <= sr[i-1] for 1 <= i < DEPTH; with wea=0 storage holds.
REQ-019 Position 0 SHALL be the newest word; position k the word pushed k pushes earlier.
REQ-020 fill_count SHALL increment by 1 per push, saturating at DEPTH; never wraps.
REQ-021 flush=1 SHALL set fill_count to 0; flush and wea in the same cycle: data pushed, fill_count = 1.
REQ-022 Storage SHALL not be cleared by flush or reset (SRL inference); only tracking state resets.
REQ-023 Per tap, comb read: data_t = sr[addrb_t] when addrb_t < DEPTH, else 0; err_t = (addrb_t >= DEPTH); val_t = (addrb_t < fill_count) and not err_t.
REQ-024 NUM_REGISTER_OUTPUT=0: dob, dob_valid, addr_err SHALL equal comb data/val/err, zero latency.
REQ-025 NUM_REGISTER_OUTPUT=1: on clk edge with reb[t]=1, tap t registers data/val/err (one-cycle latency); with reb[t]=0 tap t outputs hold.
REQ-026 NUM_REGISTER_OUTPUT=1, reb and wea same cycle: registered value SHALL be the pre-push contents and pre-push fill_count.
REQ-027 Taps SHALL be fully independent; any taps may address the same position simultaneously.
REQ-028 Illegal parameter values SHALL cause $fatal at elaboration.

Reset
REQ-029 rst_n low SHALL immediately, without clock, force fill_count=0, full=0.
REQ-030 rst_n low SHALL force registered dob=0, dob_valid=0, addr_err=0 when NUM_REGISTER_OUTPUT=1.
REQ-031 Reset mid-operation: after release, all positions report dob_valid=0 until re-pushed; pushes in the release cycle's following edge count normally.

Configuration
REQ-032 Macro SRM_FILL_TRACK_EN defined: fill_count, full, flush and dob_valid behave per REQ-016..REQ-031.
REQ-033 SRM_FILL_TRACK_EN undefined: no fill counter; fill_count tied 0, full tied 0, flush ignored, val_t = not err_t.

Verification (DATA_WIDTH=8, DEPTH=16, NUM_TAPS=2, macro defined unless stated)
REQ-034 Reset, push 0x01..0x05, tap0 addr 0, tap1 addr 4 -> dob0=0x05, dob1=0x01, both valid, fill_count=5; tap1 addr 5 -> dob_valid[1]=0.
REQ-035 Push 0x00..0x13 (20 words) -> fill_count=16, full=1; addr 15 -> 0x04 valid, addr 0 -> 0x13.
REQ-036 After 16 pushes assert flush with wea, dia=0xAA -> fill_count=1, addr 0 -> 0xAA valid, addr 1 -> 0x0F data, valid 0.
REQ-037 NUM_REGISTER_OUTPUT=1: reb[0]=1 with wea same cycle, addr 0 -> next cycle dob0 = previous newest; reb[0]=0 -> dob0 holds while pushes continue.
REQ-038 DEPTH=12: addr 13 -> addr_err=1, dob=0, dob_valid=0; addr 11 -> addr_err=0.
REQ-039 Drop rst_n between edges after 7 pushes -> fill_count=0, full=0 asynchronously; macro undefined build: dob_valid=1 for any addr < DEPTH after reset.

Source files
------------

// File: rtl/shift_register_multitap.sv
// Multi-tap shift register: push at position 0, independent dynamic read taps.
// Optional fill tracking (fill_count, full, flush, dob_valid) enabled by macro SRM_FILL_TRACK_EN.
module shift_register_multitap #(
  parameter int DATA_WIDTH          = 8,
  parameter int DEPTH               = 16,
  parameter int NUM_TAPS            = 2,
  parameter int NUM_REGISTER_OUTPUT = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wea,
  input  logic [DATA_WIDTH-1:0]          dia,
  input  logic                           flush,
  input  logic [NUM_TAPS-1:0]            reb,
  input  logic [NUM_TAPS*AW-1:0]         addrb,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] dob,
  output logic [NUM_TAPS-1:0]            dob_valid,
  output logic [NUM_TAPS-1:0]            addr_err,
  output logic [CW-1:0]                  fill_count,
  output logic                           full
);

  if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
    $fatal(1, "shift_register_multitap: DEPTH must be in 2..1024");
  end
  if (NUM_TAPS < 1 || NUM_TAPS > 8) begin : g_bad_taps
    $fatal(1, "shift_register_multitap: NUM_TAPS must be in 1..8");
  end
  if (NUM_REGISTER_OUTPUT != 0 && NUM_REGISTER_OUTPUT != 1) begin : g_bad_lat
    $fatal(1, "shift_register_multitap: NUM_REGISTER_OUTPUT must be 0 or 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "shift_register_multitap: DATA_WIDTH must be positive");
  end

  logic [DATA_WIDTH-1:0]          sr_q [DEPTH];
  logic [DATA_WIDTH-1:0]          sr_d [DEPTH];
  logic [NUM_TAPS*DATA_WIDTH-1:0] data_s;
  logic [NUM_TAPS-1:0]            val_s;
  logic [NUM_TAPS-1:0]            err_s;
  logic [AW-1:0]                  tap_addr_s;

  always_comb begin
    sr_d = sr_q;
    if (wea) begin
      sr_d[0] = dia;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Storage has no reset so it can map onto shift-register primitives.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

`ifdef SRM_FILL_TRACK_EN
  logic [CW-1:0] fill_q;
  logic [CW-1:0] fill_d;

  always_comb begin
    fill_d = fill_q;
    if (flush) begin
      fill_d = wea ? CW'(1) : CW'(0);
    end else if (wea && (fill_q != CW'(DEPTH))) begin
      fill_d = fill_q + CW'(1);
    end else begin
      fill_d = fill_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill_count = fill_q;
  assign full       = (fill_q == CW'(DEPTH));
`else
  logic unused_flush_s;
  assign unused_flush_s = flush;
  assign fill_count     = '0;
  assign full           = 1'b0;
`endif

  always_comb begin
    data_s     = '0;
    val_s      = '0;
    err_s      = '0;
    tap_addr_s = '0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      tap_addr_s = addrb[t*AW +: AW];
      err_s[t]   = (32'(tap_addr_s) >= 32'(DEPTH));
      if (err_s[t]) begin
        data_s[t*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin
        data_s[t*DATA_WIDTH +: DATA_WIDTH] = sr_q[tap_addr_s];
      end
`ifdef SRM_FILL_TRACK_EN
      val_s[t] = !err_s[t] && (32'(tap_addr_s) < 32'(fill_q));
`else
      val_s[t] = !err_s[t];
`endif
    end
  end

  if (NUM_REGISTER_OUTPUT == 1) begin : g_reg_out
    logic [NUM_TAPS*DATA_WIDTH-1:0] dob_q, dob_d;
    logic [NUM_TAPS-1:0]            val_q, val_d;
    logic [NUM_TAPS-1:0]            err_q, err_d;

    // Sampling uses pre-edge storage and fill, so a same-cycle push is not yet visible.
    always_comb begin
      dob_d = dob_q;
      val_d = val_q;
      err_d = err_q;
      for (int t = 0; t < NUM_TAPS; t++) begin
        if (reb[t]) begin
          dob_d[t*DATA_WIDTH +: DATA_WIDTH] = data_s[t*DATA_WIDTH +: DATA_WIDTH];
          val_d[t] = val_s[t];
          err_d[t] = err_s[t];
        end else begin
          dob_d[t*DATA_WIDTH +: DATA_WIDTH] = dob_q[t*DATA_WIDTH +: DATA_WIDTH];
          val_d[t] = val_q[t];
          err_d[t] = err_q[t];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dob_q <= '0;
        val_q <= '0;
        err_q <= '0;
      end else begin
        dob_q <= dob_d;
        val_q <= val_d;
        err_q <= err_d;
      end
    end

    assign dob       = dob_q;
    assign dob_valid = val_q;
    assign addr_err  = err_q;
  end else begin : g_comb_out
    logic unused_reb_s;
    assign unused_reb_s = ^reb;
    assign dob          = data_s;
    assign dob_valid    = val_s;
    assign addr_err     = err_s;
  end

endmodule

// File: tb/tb_shift_register_multitap.sv
// Directed bench: three instances (DEPTH 16 comb, DEPTH 16 registered, DEPTH 12 comb).
// Expectations adapt to whether SRM_FILL_TRACK_EN is defined for the build.
module tb_shift_register_multitap;

`ifdef SRM_FILL_TRACK_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wea, flush;
  logic [7:0]  dia;
  logic [1:0]  reb;
  logic [7:0]  addrb_a, addrb_c;
  logic [15:0] dob_a, dob_b, dob_c;
  logic [1:0]  val_a, val_b, val_c, err_a, err_b, err_c;
  logic [4:0]  fc_a, fc_b;
  logic [3:0]  fc_c;
  logic        full_a, full_b, full_c;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  shift_register_multitap #(.DATA_WIDTH(8), .DEPTH(16), .NUM_TAPS(2), .NUM_REGISTER_OUTPUT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .wea(wea), .dia(dia), .flush(flush), .reb(reb), .addrb(addrb_a),
    .dob(dob_a), .dob_valid(val_a), .addr_err(err_a), .fill_count(fc_a), .full(full_a));

  shift_register_multitap #(.DATA_WIDTH(8), .DEPTH(16), .NUM_TAPS(2), .NUM_REGISTER_OUTPUT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wea(wea), .dia(dia), .flush(flush), .reb(reb), .addrb(addrb_a),
    .dob(dob_b), .dob_valid(val_b), .addr_err(err_b), .fill_count(fc_b), .full(full_b));

  shift_register_multitap #(.DATA_WIDTH(8), .DEPTH(12), .NUM_TAPS(2), .NUM_REGISTER_OUTPUT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .wea(wea), .dia(dia), .flush(flush), .reb(reb), .addrb(addrb_c),
    .dob(dob_c), .dob_valid(val_c), .addr_err(err_c), .fill_count(fc_c), .full(full_c));

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wea = 1'b1;
    dia = d;
    @(posedge clk);
    #1;
    wea = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wea = 1'b0; flush = 1'b0; dia = 8'h00; reb = 2'b00;
    addrb_a = 8'h00; addrb_c = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check_value("rst_fill", 32'(fc_a), 32'd0);
    check_value("rst_full", 32'(full_a), 32'd0);
    check_value("rst_reg_dob", 32'(dob_b), 32'd0);
    check_value("rst_reg_val", 32'(val_b), 32'd0);
    check_value("rst_reg_err", 32'(err_b), 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i <= 5; i++) push(8'(i));
    addrb_a = 8'h40; #1;
    check_value("tap_data_5", 32'(dob_a), 32'h0105);
    check_value("tap_val_5", 32'(val_a), 32'h3);
    check_value("fill_5", 32'(fc_a), FE ? 32'd5 : 32'd0);
    addrb_a = 8'h50; #1;
    check_value("tap1_past_fill", 32'(val_a[1]), FE ? 32'd0 : 32'd1);
    addrb_c = 8'hBD; #1;
    check_value("d12_err", 32'(err_c), 32'h1);
    check_value("d12_err_data", 32'(dob_c[7:0]), 32'h0);
    check_value("d12_err_val", 32'(val_c[0]), 32'd0);
    check_value("d12_addr11_val", 32'(val_c[1]), FE ? 32'd0 : 32'd1);
    addrb_c = 8'h4C; #1;
    check_value("d12_edge_err", 32'(err_c), 32'h1);
    check_value("d12_edge_data", 32'(dob_c[15:8]), 32'h01);

    addrb_a = 8'h00; reb = 2'b01;
    push(8'h06);
    check_value("reg_prepush_data", 32'(dob_b), 32'h0005);
    check_value("reg_prepush_val", 32'(val_b), 32'h1);
    check_value("comb_postpush", 32'(dob_a[7:0]), 32'h06);
    reb = 2'b00;
    push(8'h07);
    check_value("reg_hold", 32'(dob_b[7:0]), 32'h05);
    reb = 2'b01;
    @(posedge clk); #1;
    reb = 2'b00;
    check_value("reg_reload", 32'(dob_b[7:0]), 32'h07);

    rst_n = 1'b0; #1;
    check_value("async_fill", 32'(fc_a), 32'd0);
    check_value("async_full", 32'(full_a), 32'd0);
    check_value("async_reg_dob", 32'(dob_b), 32'd0);
    check_value("async_reg_val", 32'(val_b), 32'd0);
    addrb_a = 8'h30; #1;
    check_value("post_rst_val", 32'(val_a), FE ? 32'h0 : 32'h3);
    check_value("post_rst_keep", 32'(dob_a[7:0]), 32'h07);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) push(8'(i));
    check_value("fill_15", 32'(fc_a), FE ? 32'd15 : 32'd0);
    check_value("full_15", 32'(full_a), 32'd0);
    push(8'h0F);
    check_value("fill_16", 32'(fc_a), FE ? 32'd16 : 32'd0);
    check_value("full_16", 32'(full_a), FE ? 32'd1 : 32'd0);
    for (int i = 16; i < 20; i++) push(8'(i));
    check_value("fill_sat", 32'(fc_a), FE ? 32'd16 : 32'd0);
    check_value("full_sat", 32'(full_a), FE ? 32'd1 : 32'd0);
    check_value("d12_full", 32'(full_c), FE ? 32'd1 : 32'd0);
    addrb_a = 8'hF0; #1;
    check_value("oldest_newest", 32'(dob_a), 32'h0413);
    check_value("oldest_val", 32'(val_a), 32'h3);
    addrb_c = 8'h0B; #1;
    check_value("d12_addr11", 32'(dob_c[7:0]), 32'h08);
    check_value("d12_addr11_ok", 32'(err_c), 32'h0);

    addrb_a = 8'h10; flush = 1'b1;
    push(8'hAA);
    flush = 1'b0;
    check_value("flush_push_fill", 32'(fc_a), FE ? 32'd1 : 32'd0);
    check_value("flush_push_full", 32'(full_a), 32'd0);
    check_value("flush_push_data", 32'(dob_a), 32'h13AA);
    check_value("flush_push_val", 32'(val_a), FE ? 32'h1 : 32'h3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_value("flush_only_fill", 32'(fc_a), 32'd0);
    check_value("flush_only_data", 32'(dob_a[7:0]), 32'hAA);
    check_value("flush_only_val", 32'(val_a), FE ? 32'h0 : 32'h3);
    push(8'hBB);
    check_value("repush_fill", 32'(fc_a), FE ? 32'd1 : 32'd0);
    check_value("repush_data", 32'(dob_a), 32'hAABB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
